// File: rtl/pc_cfr_pkg.sv
// Shared types and arithmetic helpers for the CFR cancellation pulse generator.
// Complex sample/product types, the complex multiplier and the output rounding/saturation.
package pc_cfr_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int PROD_WIDTH = 2 * DATA_WIDTH + 1;
    // Sum headroom covers up to 16 engines.
    localparam int SUM_WIDTH  = PROD_WIDTH + 4;

    localparam logic signed [SUM_WIDTH-1:0] SAT_MAX =
        {{(SUM_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_WIDTH-1:0] SAT_MIN =
        {{(SUM_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] i;
        logic signed [DATA_WIDTH-1:0] q;
    } cpx_t;

    typedef struct packed {
        logic signed [PROD_WIDTH-1:0] i;
        logic signed [PROD_WIDTH-1:0] q;
    } cpx_prod_t;

    typedef enum logic {
        ENG_IDLE = 1'b0,
        ENG_RUN  = 1'b1
    } eng_state_t;

    function automatic cpx_prod_t cpx_mult(input cpx_t s, input cpx_t w);
        logic signed [2*DATA_WIDTH-1:0] ii;
        logic signed [2*DATA_WIDTH-1:0] qq;
        logic signed [2*DATA_WIDTH-1:0] iq;
        logic signed [2*DATA_WIDTH-1:0] qi;
        cpx_prod_t p;
        ii  = $signed(s.i) * $signed(w.i);
        qq  = $signed(s.q) * $signed(w.q);
        iq  = $signed(s.i) * $signed(w.q);
        qi  = $signed(s.q) * $signed(w.i);
        p.i = {ii[2*DATA_WIDTH-1], ii} - {qq[2*DATA_WIDTH-1], qq};
        p.q = {iq[2*DATA_WIDTH-1], iq} + {qi[2*DATA_WIDTH-1], qi};
        return p;
    endfunction

    // Round half-up, arithmetic shift right, clamp to the signed output range.
    function automatic logic signed [DATA_WIDTH-1:0] sat_round(
        input logic signed [SUM_WIDTH-1:0] in_v,
        input int unsigned                 shift
    );
        logic signed [SUM_WIDTH-1:0] rnd;
        rnd = in_v + (SUM_WIDTH'(1'b1) << (shift - 1));
        rnd = rnd >>> shift;
        if (rnd > SAT_MAX) begin
            rnd = SAT_MAX;
        end else if (rnd < SAT_MIN) begin
            rnd = SAT_MIN;
        end else begin
            rnd = rnd;
        end
        return rnd[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/pc_cfr_cpg_engine.sv
// One cancellation pulse playback engine: run/idle FSM, CPW address counter,
// latched peak scale and the registered complex product of scale x CPW sample.
module pc_cfr_cpg_engine
    import pc_cfr_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  cpx_t                  scale_i,
    input  cpx_t                  rd_data_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  busy_o,
    output cpx_prod_t             prod_o
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    eng_state_t            state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    cpx_t                  scale_q;
    logic                  rd_vld_q;
    cpx_prod_t             prod_q;

    // FSM, address counter, scale latch and product pipeline stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ENG_IDLE;
            addr_q   <= '0;
            scale_q  <= '0;
            rd_vld_q <= 1'b0;
            prod_q   <= '0;
        end else begin
            case (state_q)
                ENG_IDLE: begin
                    if (start_i) begin
                        state_q <= ENG_RUN;
                        addr_q  <= '0;
                        scale_q <= scale_i;
                    end
                end
                ENG_RUN: begin
                    if (addr_q == ADDR_LAST) begin
                        state_q <= ENG_IDLE;
                        addr_q  <= '0;
                    end else begin
                        addr_q  <= addr_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ENG_IDLE;
                    addr_q  <= '0;
                end
            endcase
            // Scale cannot change while a sample of the current pulse is in flight.
            rd_vld_q <= (state_q == ENG_RUN);
            prod_o_stage: begin
                if (rd_vld_q) begin
                    prod_q <= cpx_mult(scale_q, rd_data_i);
                end else begin
                    prod_q <= '0;
                end
            end
        end
    end

    assign addr_o = addr_q;
    assign busy_o = (state_q == ENG_RUN);
    assign prod_o = prod_q;

endmodule

// File: rtl/pc_cfr_cpg.sv
// Cancellation pulse generator: CPW RAM, peak-to-engine allocator, drop counter
// and the summing/rounding output stage over all playback engines.
module pc_cfr_cpg
    import pc_cfr_pkg::*;
#(
    parameter int CPW_ADDR_WIDTH = 8,
    parameter int NUM_CPG        = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ctrl_enable,
    input  logic                      ctrl_cpw_wr_en,
    input  logic [CPW_ADDR_WIDTH-1:0] ctrl_cpw_wr_addr,
    input  logic [DATA_WIDTH-1:0]     ctrl_cpw_wr_data_i,
    input  logic [DATA_WIDTH-1:0]     ctrl_cpw_wr_data_q,
    input  logic                      peak_valid,
    input  logic [DATA_WIDTH-1:0]     peak_scale_i,
    input  logic [DATA_WIDTH-1:0]     peak_scale_q,
    output logic [DATA_WIDTH-1:0]     cp_i_out,
    output logic [DATA_WIDTH-1:0]     cp_q_out,
    output logic [NUM_CPG-1:0]        ctrl_busy,
    output logic [15:0]               ctrl_drop_count
);

    cpx_t                      cpw_mem [2**CPW_ADDR_WIDTH];
    cpx_t                      rd_data_q [NUM_CPG];
    logic [CPW_ADDR_WIDTH-1:0] eng_addr_s [NUM_CPG];
    cpx_prod_t                 eng_prod_s [NUM_CPG];
    logic [NUM_CPG-1:0]        busy_s;
    logic [NUM_CPG-1:0]        alloc_s;
    logic                      take_s;
    logic                      drop_s;
    cpx_t                      peak_scale_s;
    logic signed [SUM_WIDTH-1:0] sum_i_s;
    logic signed [SUM_WIDTH-1:0] sum_q_s;
    logic [15:0]               drop_cnt_q;
    logic [DATA_WIDTH-1:0]     cp_i_q;
    logic [DATA_WIDTH-1:0]     cp_q_q;

    assign take_s       = peak_valid & ctrl_enable;
    assign drop_s       = take_s & (&busy_s);
    assign peak_scale_s = cpx_t'{i: peak_scale_i, q: peak_scale_q};

    // CPW storage write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ctrl_cpw_wr_en) begin
            cpw_mem[ctrl_cpw_wr_addr] <= cpx_t'{i: ctrl_cpw_wr_data_i, q: ctrl_cpw_wr_data_q};
        end
    end

    // One registered read port per engine; a same-address write returns old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_CPG; n++) begin
                rd_data_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CPG; n++) begin
                rd_data_q[n] <= cpw_mem[eng_addr_s[n]];
            end
        end
    end

    // Grant the peak to the lowest-index engine idle in this cycle.
    always_comb begin
        logic found_v;
        alloc_s = '0;
        found_v = 1'b0;
        for (int n = 0; n < NUM_CPG; n++) begin
            if (take_s && !found_v && !busy_s[n]) begin
                alloc_s[n] = 1'b1;
                found_v    = 1'b1;
            end else begin
                alloc_s[n] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CPG; g++) begin : g_eng
        pc_cfr_cpg_engine #(
            .ADDR_WIDTH (CPW_ADDR_WIDTH)
        ) u_eng (
            .clk       (clk),
            .rst_n     (rst_n),
            .start_i   (alloc_s[g]),
            .scale_i   (peak_scale_s),
            .rd_data_i (rd_data_q[g]),
            .addr_o    (eng_addr_s[g]),
            .busy_o    (busy_s[g]),
            .prod_o    (eng_prod_s[g])
        );
    end

    // Sum of all engine products; idle engines already present zero.
    always_comb begin
        sum_i_s = '0;
        sum_q_s = '0;
        for (int n = 0; n < NUM_CPG; n++) begin
            sum_i_s = sum_i_s + $signed(eng_prod_s[n].i);
            sum_q_s = sum_q_s + $signed(eng_prod_s[n].q);
        end
    end

    // Output register and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cp_i_q     <= '0;
            cp_q_q     <= '0;
            drop_cnt_q <= 16'h0000;
        end else begin
            cp_i_q <= sat_round(sum_i_s, DATA_WIDTH - 1);
            cp_q_q <= sat_round(sum_q_s, DATA_WIDTH - 1);
            if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign cp_i_out        = cp_i_q;
    assign cp_q_out        = cp_q_q;
    assign ctrl_busy       = busy_s;
    assign ctrl_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_pc_cfr_cpg.sv
// Directed bench for pc_cfr_cpg: literal expected values plus a small
// superposition model of accepted peaks for overlapping-pulse checks.
module tb_pc_cfr_cpg;

    localparam int AW  = 8;
    localparam int NE  = 4;
    localparam int DW  = 16;
    localparam int LEN = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ctrl_enable;
    logic          ctrl_cpw_wr_en;
    logic [AW-1:0] ctrl_cpw_wr_addr;
    logic [DW-1:0] ctrl_cpw_wr_data_i;
    logic [DW-1:0] ctrl_cpw_wr_data_q;
    logic          peak_valid;
    logic [DW-1:0] peak_scale_i;
    logic [DW-1:0] peak_scale_q;
    logic [DW-1:0] cp_i_out;
    logic [DW-1:0] cp_q_out;
    logic [NE-1:0] ctrl_busy;
    logic [15:0]   ctrl_drop_count;

    always #5 clk = ~clk;

    pc_cfr_cpg #(.CPW_ADDR_WIDTH(AW), .NUM_CPG(NE)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ctrl_enable        (ctrl_enable),
        .ctrl_cpw_wr_en     (ctrl_cpw_wr_en),
        .ctrl_cpw_wr_addr   (ctrl_cpw_wr_addr),
        .ctrl_cpw_wr_data_i (ctrl_cpw_wr_data_i),
        .ctrl_cpw_wr_data_q (ctrl_cpw_wr_data_q),
        .peak_valid         (peak_valid),
        .peak_scale_i       (peak_scale_i),
        .peak_scale_q       (peak_scale_q),
        .cp_i_out           (cp_i_out),
        .cp_q_out           (cp_q_out),
        .ctrl_busy          (ctrl_busy),
        .ctrl_drop_count    (ctrl_drop_count)
    );

    typedef struct { int t0; int si; int sq; } peak_t;
    peak_t pk_q[$];
    int    cpw_i [LEN];
    int    cpw_q [LEN];
    int    cyc;
    int    tests_run;
    int    tests_failed;
    int    exp_drop;

    task automatic check(input string tag, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected output: rounded, saturated sum of all accepted pulses at this cycle.
    function automatic int model(input bit is_q);
        longint acc;
        longint r;
        int     k;
        acc = 0;
        foreach (pk_q[j]) begin
            k = cyc - 4 - pk_q[j].t0;
            if (k >= 0 && k < LEN) begin
                if (!is_q)
                    acc += longint'(pk_q[j].si) * cpw_i[k] - longint'(pk_q[j].sq) * cpw_q[k];
                else
                    acc += longint'(pk_q[j].si) * cpw_q[k] + longint'(pk_q[j].sq) * cpw_i[k];
            end
        end
        r = (acc + 16384) >>> 15;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic check_out(input string tag);
        check({tag, "_i"}, int'($signed(cp_i_out)), model(1'b0));
        check({tag, "_q"}, int'($signed(cp_q_out)), model(1'b1));
    endtask

    task automatic run_check(input int n, input string tag);
        for (int c = 0; c < n; c++) begin
            check_out(tag);
            tick();
        end
    endtask

    task automatic write_cpw(input int a, input int wi, input int wq);
        ctrl_cpw_wr_en     = 1'b1;
        ctrl_cpw_wr_addr   = AW'(a);
        ctrl_cpw_wr_data_i = DW'(wi);
        ctrl_cpw_wr_data_q = DW'(wq);
        cpw_i[a] = wi;
        cpw_q[a] = wq;
        tick();
        ctrl_cpw_wr_en = 1'b0;
    endtask

    task automatic peak(input int si, input int sq, input bit accepted);
        peak_t p;
        peak_valid   = 1'b1;
        peak_scale_i = DW'(si);
        peak_scale_q = DW'(sq);
        p.t0 = cyc;
        p.si = si;
        p.sq = sq;
        if (accepted) pk_q.push_back(p);
        else if (ctrl_enable) exp_drop++;
        tick();
        peak_valid = 1'b0;
    endtask

    initial begin
        cyc = 0; tests_run = 0; tests_failed = 0; exp_drop = 0;
        rst_n = 1'b0; ctrl_enable = 1'b1; ctrl_cpw_wr_en = 1'b0;
        ctrl_cpw_wr_addr = '0; ctrl_cpw_wr_data_i = '0; ctrl_cpw_wr_data_q = '0;
        peak_valid = 1'b0; peak_scale_i = '0; peak_scale_q = '0;
        repeat (3) tick();
        check("rst_cp_i", int'(cp_i_out), 0);
        check("rst_cp_q", int'(cp_q_out), 0);
        check("rst_busy", int'(ctrl_busy), 0);
        check("rst_drop", int'(ctrl_drop_count), 0);
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < LEN; k++) write_cpw(k, k * 64, 0);

        // Single pulse, scale ~1.0: output follows the ramp
        peak(32767, 0, 1'b1);
        check("a_busy_c1", int'(ctrl_busy), 1);
        repeat (3) tick();
        check("a_k0_i", int'($signed(cp_i_out)), 0);
        tick();
        check("a_k1_i", int'($signed(cp_i_out)), 64);
        repeat (99) tick();
        check("a_k100_i", int'($signed(cp_i_out)), 6400);
        check("a_k100_q", int'($signed(cp_q_out)), 0);
        repeat (155) tick();
        check("a_k255_i", int'($signed(cp_i_out)), 16320);
        tick();
        check("a_end_i", int'($signed(cp_i_out)), 0);
        check("a_end_busy", int'(ctrl_busy), 0);
        pk_q.delete();
        repeat (4) tick();

        // 90-degree rotation, half amplitude
        peak(0, 16384, 1'b1);
        repeat (13) tick();
        check("b_k10_q", int'($signed(cp_q_out)), 320);
        check("b_k10_i", int'($signed(cp_i_out)), 0);
        repeat (245) tick();
        check("b_k255_q", int'($signed(cp_q_out)), 8160);
        tick();
        check("b_end_q", int'($signed(cp_q_out)), 0);
        pk_q.delete();
        repeat (4) tick();

        // Disabled: peak neither runs nor counts
        ctrl_enable = 1'b0;
        peak(32767, 0, 1'b0);
        tick();
        check("c_dis_busy", int'(ctrl_busy), 0);
        check("c_dis_drop", int'(ctrl_drop_count), exp_drop);
        ctrl_enable = 1'b1;
        repeat (4) tick();

        // Five consecutive peaks: four engines, one drop
        for (int j = 0; j < 4; j++) peak(32767, 0, 1'b1);
        peak(32767, 0, 1'b0);
        check("d_busy_all", int'(ctrl_busy), 15);
        check("d_drop", int'(ctrl_drop_count), 1);
        run_check(265, "d_super");
        check("d_idle_busy", int'(ctrl_busy), 0);
        pk_q.delete();
        repeat (4) tick();

        // Peak in engine 0's last-address cycle goes to engine 1
        peak(16384, 0, 1'b1);
        repeat (255) tick();
        check("e_last_busy", int'(ctrl_busy), 1);
        peak(16384, 0, 1'b1);
        check("e_eng1", int'(ctrl_busy), 2);
        peak(16384, 0, 1'b1);
        check("e_eng0_again", int'(ctrl_busy), 3);
        run_check(265, "e_out");
        pk_q.delete();
        repeat (4) tick();

        // Saturation: two full-scale pulses overlap
        for (int k = 0; k < 8; k++) write_cpw(k, 32767, 0);
        peak(32767, 0, 1'b1);
        peak(32767, 0, 1'b1);
        repeat (3) tick();
        check("f_pos_sat", int'($signed(cp_i_out)), 32767);
        run_check(262, "f_pos");
        pk_q.delete();
        repeat (4) tick();
        peak(-32768, 0, 1'b1);
        peak(-32768, 0, 1'b1);
        repeat (3) tick();
        check("f_neg_sat", int'($signed(cp_i_out)), -32768);
        run_check(262, "f_neg");
        pk_q.delete();
        repeat (4) tick();

        // Reset mid-pulse, then replay with CPW intact
        peak(12345, -2000, 1'b1);
        repeat (10) tick();
        check("g_pre_busy", int'(ctrl_busy), 1);
        rst_n = 1'b0;
        #2;
        check("g_rst_i", int'(cp_i_out), 0);
        check("g_rst_q", int'(cp_q_out), 0);
        check("g_rst_busy", int'(ctrl_busy), 0);
        check("g_rst_drop", int'(ctrl_drop_count), 0);
        pk_q.delete();
        exp_drop = 0;
        tick();
        rst_n = 1'b1;
        tick();
        peak(12345, -2000, 1'b1);
        run_check(262, "g_replay");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
